// File: rtl/uart_tx_arb_pkg.sv
// Shared types and defaults for the two-requester UART transmit arbiter.
// Holds the FSM state encoding and the default bus widths.
package uart_tx_arb_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 8;

    typedef logic [1:0] req_vec_t;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_READ      = 3'd1,
        S_LOAD      = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_DONE      = 3'd4
    } state_t;

endpackage

// File: rtl/uart_tx_rr_arb2.sv
// Two-input round-robin grant with last-grant memory.
// Grant is combinational; the history updates when a frame finishes.
module uart_tx_rr_arb2
    import uart_tx_arb_pkg::*;
(
    input  logic     i_clk,
    input  logic     i_reset,
    input  req_vec_t req,
    input  logic     update,
    input  logic     owner_is1,
    output req_vec_t gnt
);

    logic last1;

    // Requester 1 is "last" out of reset so requester 0 wins the first tie.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            last1 <= 1'b1;
        end else if (update) begin
            last1 <= owner_is1;
        end
    end

    always_comb begin
        gnt = 2'b00;
        if (req == 2'b11) begin
            gnt = last1 ? 2'b01 : 2'b10;
        end else begin
            gnt = req;
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Arbitrates two frame memories onto one UART transmitter, byte by byte.
// Frame length is copied at grant so re-requests cannot disturb a frame.
module uart_tx_arb
    import uart_tx_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_req0_wdone,
    input  logic [ADDR_W-1:0] i_req0_len,
    output logic              o_req0_ren,
    output logic [ADDR_W-1:0] o_req0_raddr,
    input  logic [DATA_W-1:0] i_req0_rdata,
    input  logic              i_req1_wdone,
    input  logic [ADDR_W-1:0] i_req1_len,
    output logic              o_req1_ren,
    output logic [ADDR_W-1:0] o_req1_raddr,
    input  logic [DATA_W-1:0] i_req1_rdata,
    output logic              o_tx_dv,
    output logic [DATA_W-1:0] o_tx_byte,
    input  logic              i_tx_done,
    output logic [1:0]        o_grant,
    output logic              o_frame_done,
    output logic [1:0]        o_drop
);

    state_t            state;
    state_t            state_nx;
    req_vec_t          pending;
    req_vec_t          set;
    req_vec_t          drop;
    req_vec_t          clr;
    req_vec_t          gnt;
    req_vec_t          owner;
    req_vec_t          drop_q;
    logic              take;
    logic              active;
    logic [ADDR_W-1:0] len0;
    logic [ADDR_W-1:0] len1;
    logic [ADDR_W-1:0] frame_len;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] idx_inc;
    logic [DATA_W-1:0] tx_byte_q;
    logic [DATA_W-1:0] rdata_sel;

    assign set[0]  = i_req0_wdone && (i_req0_len != '0) && !pending[0];
    assign set[1]  = i_req1_wdone && (i_req1_len != '0) && !pending[1];
    assign drop[0] = i_req0_wdone && !set[0];
    assign drop[1] = i_req1_wdone && !set[1];

    assign take    = (state == S_IDLE) && (pending != 2'b00);
    assign clr     = take ? gnt : 2'b00;
    assign idx_inc = idx + {{(ADDR_W-1){1'b0}}, 1'b1};

    uart_tx_rr_arb2 u_rr (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .req       (pending),
        .update    (state == S_DONE),
        .owner_is1 (owner[1]),
        .gnt       (gnt)
    );

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:      if (take) state_nx = S_READ;
            S_READ:      state_nx = S_LOAD;
            S_LOAD:      state_nx = S_WAIT_DONE;
            S_WAIT_DONE: begin
                if (i_tx_done) begin
                    state_nx = (idx_inc == frame_len) ? S_DONE : S_READ;
                end
            end
            S_DONE:      state_nx = S_IDLE;
            default:     state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            pending   <= 2'b00;
            drop_q    <= 2'b00;
            owner     <= 2'b00;
            len0      <= '0;
            len1      <= '0;
            frame_len <= '0;
            idx       <= '0;
            tx_byte_q <= '0;
        end else begin
            pending <= (pending & ~clr) | set;
            drop_q  <= drop;
            if (set[0]) len0 <= i_req0_len;
            if (set[1]) len1 <= i_req1_len;
            if (take) begin
                owner     <= gnt;
                frame_len <= gnt[1] ? len1 : len0;
                idx       <= '0;
            end else if (state == S_WAIT_DONE && i_tx_done) begin
                idx <= idx_inc;
            end
            if (state == S_DONE) owner <= 2'b00;
            if (state == S_LOAD) tx_byte_q <= rdata_sel;
        end
    end

    assign rdata_sel = owner[1] ? i_req1_rdata : i_req0_rdata;
    assign active    = (state == S_READ) || (state == S_LOAD) ||
                       (state == S_WAIT_DONE);

    assign o_req0_ren   = (state == S_READ) && owner[0];
    assign o_req1_ren   = (state == S_READ) && owner[1];
    assign o_req0_raddr = o_req0_ren ? idx : '0;
    assign o_req1_raddr = o_req1_ren ? idx : '0;

    // Byte is live from the memory in LOAD, then held until the next LOAD.
    assign o_tx_dv      = (state == S_LOAD);
    assign o_tx_byte    = (state == S_LOAD) ? rdata_sel : tx_byte_q;
    assign o_grant      = active ? owner : 2'b00;
    assign o_frame_done = (state == S_DONE);
    assign o_drop       = drop_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Scoreboard bench for uart_tx_arb: frame-level model, random and directed traffic.
// Expected bytes, drops, frame lengths and dv times are queued and checked by a monitor.
module tb_uart_tx_arb;

    localparam int AW = 10;
    localparam int DW = 8;

    typedef struct {
        int        own;
        int        addr;
        logic [7:0] data;
    } item_t;

    logic          i_clk = 1'b0;
    logic          i_reset;
    logic          i_req0_wdone;
    logic [AW-1:0] i_req0_len;
    logic          o_req0_ren;
    logic [AW-1:0] o_req0_raddr;
    logic [DW-1:0] i_req0_rdata;
    logic          i_req1_wdone;
    logic [AW-1:0] i_req1_len;
    logic          o_req1_ren;
    logic [AW-1:0] o_req1_raddr;
    logic [DW-1:0] i_req1_rdata;
    logic          o_tx_dv;
    logic [DW-1:0] o_tx_byte;
    logic          i_tx_done;
    logic [1:0]    o_grant;
    logic          o_frame_done;
    logic [1:0]    o_drop;

    uart_tx_arb #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_req0_wdone (i_req0_wdone),
        .i_req0_len   (i_req0_len),
        .o_req0_ren   (o_req0_ren),
        .o_req0_raddr (o_req0_raddr),
        .i_req0_rdata (i_req0_rdata),
        .i_req1_wdone (i_req1_wdone),
        .i_req1_len   (i_req1_len),
        .o_req1_ren   (o_req1_ren),
        .o_req1_raddr (o_req1_raddr),
        .i_req1_rdata (i_req1_rdata),
        .o_tx_dv      (o_tx_dv),
        .o_tx_byte    (o_tx_byte),
        .i_tx_done    (i_tx_done),
        .o_grant      (o_grant),
        .o_frame_done (o_frame_done),
        .o_drop       (o_drop)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    // Synchronous-read frame memories; junk on the bus when not read.
    logic [7:0] mem0 [1024];
    logic [7:0] mem1 [1024];
    always @(posedge i_clk) begin
        i_req0_rdata <= o_req0_ren ? mem0[o_req0_raddr] : 8'($urandom);
        i_req1_rdata <= o_req1_ren ? mem1[o_req1_raddr] : 8'($urandom);
    end

    int ncmp = 0;
    int nbad = 0;

    item_t      iq[$];
    int         tq[$];
    int         fdq[$];
    logic [1:0] dq[$];

    // Reference model state (frame level).
    bit [1:0] pend;
    int       plen [2];
    bit       last1;
    bit       busy;
    int       own;
    int       left;
    int       done_at;
    int       quiet;
    int       dly_fix;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        pend = 2'b00;
        plen[0] = 0;
        plen[1] = 0;
        last1 = 1'b1;
        busy = 1'b0;
        own = 0;
        left = 0;
        done_at = -1;
        quiet = 0;
        iq.delete();
        tq.delete();
        fdq.delete();
        dq.delete();
    endtask

    task automatic arbitrate(input int t0);
        int o;
        if (pend == 2'b11) o = last1 ? 0 : 1;
        else o = pend[1] ? 1 : 0;
        pend[o] = 1'b0;
        own = o;
        busy = 1'b1;
        left = plen[o];
        for (int k = 0; k < plen[o]; k++) begin
            iq.push_back('{o, k, (o == 1) ? mem1[k] : mem0[k]});
        end
        fdq.push_back(plen[o]);
        tq.push_back(t0);
    endtask

    // One clock of stimulus, UART model and reference model.
    task automatic step(input bit w0, input int l0, input bit w1, input int l1);
        bit fin;
        logic [1:0] dv;
        fin = 1'b0;
        if (quiet > 0) begin
            w0 = 1'b0;
            w1 = 1'b0;
            quiet--;
        end
        i_tx_done = 1'b0;
        if (o_tx_dv) begin
            done_at = cyc + ((dly_fix > 0) ? dly_fix : int'($urandom_range(1, 5)));
        end
        if (done_at == cyc) begin
            i_tx_done = 1'b1;
            done_at = -1;
            left--;
            if (left == 0) fin = 1'b1;
            else tq.push_back(cyc + 2);
        end
        i_req0_wdone = w0;
        i_req1_wdone = w1;
        i_req0_len = w0 ? AW'(l0) : AW'($urandom);
        i_req1_len = w1 ? AW'(l1) : AW'($urandom);
        dv = 2'b00;
        if (w0) begin
            if (l0 == 0 || pend[0]) dv[0] = 1'b1;
            else begin pend[0] = 1'b1; plen[0] = l0; end
        end
        if (w1) begin
            if (l1 == 0 || pend[1]) dv[1] = 1'b1;
            else begin pend[1] = 1'b1; plen[1] = l1; end
        end
        if (dv != 2'b00) dq.push_back(dv);
        if (fin) begin
            busy = 1'b0;
            last1 = (own == 1);
            quiet = 2;
            if (pend != 2'b00) arbitrate(cyc + 4);
        end else if (!busy && pend != 2'b00) begin
            arbitrate(cyc + 3);
            quiet = 2;
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic issue(input bit w0, input int l0, input bit w1, input int l1);
        while (quiet > 0) step(0, 0, 0, 0);
        step(w0, l0, w1, l1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((busy || done_at >= 0 || iq.size() != 0) && n < 20000) begin
            step(0, 0, 0, 0);
            n++;
        end
        if (n >= 20000) begin
            ncmp++;
            nbad++;
            $display("FAIL drain_timeout: got %0d cycles expected < 20000", n);
        end
        repeat (4) step(0, 0, 0, 0);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an output.
    bit         seen;
    bit         obs_port;
    logic [AW-1:0] obs_addr;
    int         nbytes;

    always @(negedge i_clk) begin
        if (!i_reset) begin
            seen = 1'b0;
            nbytes = 0;
        end else begin
            if (o_req0_ren || o_req1_ren) begin
                if (o_req0_ren) check("idle_port1", {o_req1_ren, o_req1_raddr}, 0);
                else check("idle_port0", {o_req0_ren, o_req0_raddr}, 0);
                obs_port = o_req1_ren;
                obs_addr = o_req1_ren ? o_req1_raddr : o_req0_raddr;
                seen = 1'b1;
            end
            if (o_tx_dv) begin
                if (iq.size() == 0 || tq.size() == 0) begin
                    ncmp++;
                    nbad++;
                    $display("FAIL unexpected_dv: got dv at cycle %0d expected none", cyc);
                end else begin
                    item_t it;
                    int t;
                    it = iq.pop_front();
                    t = tq.pop_front();
                    check("read_port", seen ? {31'd0, obs_port} : 32'd2, it.own);
                    check("read_addr", seen ? 32'(obs_addr) : 32'hffff, it.addr);
                    check("tx_byte", o_tx_byte, it.data);
                    check("grant", o_grant, (it.own == 1) ? 2'b10 : 2'b01);
                    check("dv_cycle", cyc, t);
                end
                seen = 1'b0;
                nbytes++;
            end
            if (o_frame_done) begin
                if (fdq.size() == 0) begin
                    ncmp++;
                    nbad++;
                    $display("FAIL unexpected_frame_done: got pulse expected none");
                end else begin
                    check("frame_len", nbytes, fdq.pop_front());
                    check("grant_done", o_grant, 2'b00);
                end
                nbytes = 0;
            end
            if (o_drop != 2'b00) begin
                if (dq.size() == 0) begin
                    ncmp++;
                    nbad++;
                    $display("FAIL unexpected_drop: got %0b expected none", o_drop);
                end else begin
                    check("drop", o_drop, dq.pop_front());
                end
            end
        end
    end

    task automatic check_quiet_outputs(input string tag);
        check({tag, "_dv"}, o_tx_dv, 0);
        check({tag, "_grant"}, o_grant, 0);
        check({tag, "_ren"}, {o_req1_ren, o_req0_ren}, 0);
        check({tag, "_raddr"}, {o_req1_raddr, o_req0_raddr}, 0);
        check({tag, "_byte"}, o_tx_byte, 0);
        check({tag, "_fdone_drop"}, {o_frame_done, o_drop}, 0);
    endtask

    initial begin
        int n;
        int dvcnt;
        for (int i = 0; i < 1024; i++) begin
            mem0[i] = 8'($urandom);
            mem1[i] = 8'($urandom);
        end
        mem0[0] = 8'h41;
        mem0[1] = 8'h42;
        mem0[2] = 8'h43;
        model_reset();
        dly_fix = 0;
        i_reset = 1'b0;
        i_req0_wdone = 1'b0;
        i_req1_wdone = 1'b0;
        i_req0_len = '0;
        i_req1_len = '0;
        i_tx_done = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        check_quiet_outputs("reset");
        i_reset = 1'b1;
        step(0, 0, 0, 0);

        // Single frame, slow UART.
        dly_fix = 10;
        issue(1, 3, 0, 0);
        drain();

        // Tie, then a tie after req0's frame that must go to req1.
        dly_fix = 0;
        issue(1, 2, 1, 2);
        issue(1, 2, 0, 0);
        drain();

        // Drops: zero length, and a duplicate while pending.
        issue(0, 0, 1, 0);
        issue(1, 3, 0, 0);
        issue(0, 0, 1, 2);
        step(0, 0, 0, 0);
        issue(0, 0, 1, 5);
        drain();

        // Re-request by the requester being served.
        issue(1, 4, 0, 0);
        repeat (6) step(0, 0, 0, 0);
        issue(1, 4, 0, 0);
        drain();

        // Maximum-length frame.
        dly_fix = 1;
        issue(0, 0, 1, 1023);
        drain();

        // Random traffic.
        dly_fix = 0;
        for (int c = 0; c < 600; c++) begin
            step($urandom_range(0, 9) == 0, $urandom_range(0, 6),
                 $urandom_range(0, 9) == 0, $urandom_range(0, 6));
        end
        drain();

        // Reset in the middle of a 5-byte frame.
        dly_fix = 3;
        issue(1, 5, 0, 0);
        n = 0;
        while (left != 3 && n < 200) begin
            step(0, 0, 0, 0);
            n++;
        end
        check("mid_frame_reached", left, 3);
        i_reset = 1'b0;
        i_req0_wdone = 1'b0;
        i_req1_wdone = 1'b0;
        i_tx_done = 1'b0;
        #1;
        check_quiet_outputs("midreset");
        @(posedge i_clk);
        #1;
        model_reset();
        i_reset = 1'b1;
        dvcnt = 0;
        for (int c = 0; c < 20; c++) begin
            if (o_tx_dv) dvcnt++;
            step(0, 0, 0, 0);
        end
        check("dv_after_reset", dvcnt, 0);
        issue(0, 0, 1, 1);
        drain();

        check("left_items", iq.size(), 0);
        check("left_times", tq.size(), 0);
        check("left_frames", fdq.size(), 0);
        check("left_drops", dq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 Parameter: ADDR_W, default 10, width of frame length and memory read address.
REQ-002 Parameter: DATA_W, default 8, width of memory read data and UART byte.
REQ-003 i_clk  input  1  system clock; all logic on its rising edge.
REQ-004 i_reset  input  1  asynchronous, active-low reset.
REQ-005 i_req0_wdone  input  1  one-cycle pulse: requester 0 (rx memory) holds a complete frame.
REQ-006 i_req0_len  input  ADDR_W  frame byte count for requester 0; sampled only with i_req0_wdone.
REQ-007 o_req0_ren  output  1  read enable into requester 0 memory.
REQ-008 o_req0_raddr  output  ADDR_W  read address into requester 0 memory.
REQ-009 i_req0_rdata  input  DATA_W  requester 0 memory data; valid the cycle after o_req0_ren.
REQ-010 i_req1_wdone, i_req1_len, o_req1_ren, o_req1_raddr, i_req1_rdata: same widths and meanings for requester 1 (tx memory).
REQ-011 o_tx_dv  output  1  one-cycle byte-valid pulse to the UART transmitter.
REQ-012 o_tx_byte  output  DATA_W  byte to transmit; stable from the o_tx_dv pulse until i_tx_done.
REQ-013 i_tx_done  input  1  one-cycle pulse from the UART transmitter: byte finished.
REQ-014 o_grant  output  2  one-hot owner of the UART; 00 when idle.
REQ-015 o_frame_done  output  1  one-cycle pulse when the last byte of a frame completes.
REQ-016 o_drop  output  2  one-cycle pulse per requester: request discarded.

Function
REQ-017 On wdone with len != 0 and no pending request for that requester, set pending[i] and latch len[i] the next cycle.
REQ-018 On wdone with len == 0, or with pending[i] already set, discard the request and pulse o_drop[i] the next cycle; the latched len is unchanged.
REQ-019 A wdone for the requester currently being served sets pending[i]; the new frame is served after the current frame.
REQ-020 States: IDLE, READ, LOAD, WAIT_DONE, DONE.
REQ-021 IDLE: if any pending bit is set, grant one requester, clear its pending bit, set idx=0, go to READ; otherwise stay in IDLE.
REQ-022 Arbitration is round-robin: if both requesters are pending, grant the one not granted last; after reset, requester 0 wins a tie.
REQ-023 READ: drive ren=1 with raddr=idx on the granted port only, for exactly one cycle, then go to LOAD.
REQ-024 LOAD: capture the granted rdata into o_tx_byte, pulse o_tx_dv for exactly one cycle, go to WAIT_DONE.
REQ-025 WAIT_DONE: on i_tx_done, increment idx; go to DONE if idx+1 == len, else go to READ. i_tx_done in any other state is ignored.
REQ-026 DONE: pulse o_frame_done, set o_grant=00, record the last-granted requester, return to IDLE.
REQ-027 Latency: wdone in cycle N gives pending in N+1, READ in N+2 and o_tx_dv in N+3 when the block is idle.
REQ-028 Consecutive bytes: o_tx_dv rises 2 cycles after the previous i_tx_done.
REQ-029 Frame of length L issues exactly L o_tx_dv pulses and addresses 0..L-1 in order; the maximum frame is 2^ADDR_W-1 bytes.
REQ-030 The idx counter is ADDR_W bits wide and never wraps.
REQ-031 The ungranted port keeps ren=0 and raddr=0 at all times.

Reset
REQ-032 Asserting i_reset at any time, including mid-frame, immediately forces state=IDLE, pending=00, idx=0, len latches=0, last-grant=requester 1, and all outputs=0.
REQ-033 After reset deassertion, no o_tx_dv occurs until a new wdone is received; any interrupted frame is not resumed.

Structure
REQ-034 A shared package holds the state encoding constants and the ADDR_W/DATA_W defaults.
REQ-035 One sub-module, uart_tx_rr_arb2, holds the two-input round-robin grant logic and last-grant register; the FSM and datapath stay in uart_tx_arb.

Verification
REQ-036 Single frame: req0 wdone len=3 with memory bytes 0x41,0x42,0x43, UART model done 10 cycles after dv -> dv pulses carry bytes 41,42,43, raddr 0,1,2, one o_frame_done, o_grant=01 during the frame.
REQ-037 Simultaneous requests: req0 and req1 wdone in the same cycle, len=2 each -> req0 frame sent fully, then req1 frame; the next tie goes to req1.
REQ-038 Drops: req1 wdone len=0 -> o_drop=10 and no grant; req1 wdone twice while pending -> second request dropped and the first length is retained.
REQ-039 Re-request during service: req0 wdone len=4 during its own frame -> second frame of 4 bytes sent after o_frame_done.
REQ-040 Reset mid-frame: assert i_reset after byte 2 of 5 -> outputs 0 immediately, no further dv after release, and a new req1 len=1 is served normally.
REQ-041 Latency check: idle block, wdone in cycle N -> o_tx_dv in cycle N+3; next dv 2 cycles after i_tx_done.
